// File: rtl/decode_stage_param.sv
// rtl/decode_stage_param.sv - parametrised instruction decode stage with ID/EX latch
//
// Ports:
//   clk, reset            clock; synchronous active-high reset (clears register file too)
//   programCounterIn      PC+4 from IF/ID
//   instruction           IF/ID instruction word (op/rs/rt/rd/imm fields)
//   ifIdValid, flush      IF/ID slot valid; branch-taken discard of the decode slot
//   writeRegister/Data    write-back port, enabled by regWrite
//   writeBackControl      registered {regWrite, memToReg}
//   memAccessControl      registered {memRead, memWrite}
//   calculationControl    registered {regDst, aluSrc, aluOp[1:0]}
//   programCounterOut, readData1, readData2, immediateOperand, rs, rt, rd
//                         registered ID/EX data fields
//   idExValid             registered; ID/EX holds a real instruction
//   illegalInstruction    registered one-cycle flag; instruction became a bubble
//   pcWrite, ifIdWrite    combinational; 0 stalls fetch and the IF/ID latch
module decode_stage_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_COUNT      = 32,
    parameter bit LOGIC_ZERO_EXT = 1'b1,
    localparam int ADDR_W        = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] programCounterIn,
    input  logic [31:0]           instruction,
    input  logic                  ifIdValid,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [1:0]            writeBackControl,
    output logic [1:0]            memAccessControl,
    output logic [3:0]            calculationControl,
    output logic [DATA_WIDTH-1:0] programCounterOut,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [DATA_WIDTH-1:0] immediateOperand,
    output logic [ADDR_W-1:0]     rs,
    output logic [ADDR_W-1:0]     rt,
    output logic [ADDR_W-1:0]     rd,
    output logic                  idExValid,
    output logic                  illegalInstruction,
    output logic                  pcWrite,
    output logic                  ifIdWrite
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic [5:0]  opcode;
    logic [4:0]  rsField;
    logic [4:0]  rtField;
    logic [4:0]  rdField;
    logic [15:0] imm;

    assign opcode  = instruction[31:26];
    assign rsField = instruction[25:21];
    assign rtField = instruction[20:16];
    assign rdField = instruction[15:11];
    assign imm     = instruction[15:0];

    logic [ADDR_W-1:0] rsIdx;
    logic [ADDR_W-1:0] rtIdx;
    logic [ADDR_W-1:0] rdIdx;

    assign rsIdx = rsField[ADDR_W-1:0];
    assign rtIdx = rtField[ADDR_W-1:0];
    assign rdIdx = rdField[ADDR_W-1:0];

    // Decode table
    logic [1:0] decWb;
    logic [1:0] decMem;
    logic [3:0] decCalc;
    logic       knownOp;
    logic       usesRd;
    logic       rtIsSource;
    logic       logicOp;

    always_comb begin
        decWb      = 2'b00;
        decMem     = 2'b00;
        decCalc    = 4'b0000;
        knownOp    = 1'b1;
        usesRd     = 1'b0;
        rtIsSource = 1'b0;
        logicOp    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                decWb      = 2'b10;
                decCalc    = 4'b1010;
                usesRd     = 1'b1;
                rtIsSource = 1'b1;
            end
            OP_LW: begin
                decWb   = 2'b11;
                decMem  = 2'b10;
                decCalc = 4'b0100;
            end
            OP_SW: begin
                decMem     = 2'b01;
                decCalc    = 4'b0100;
                rtIsSource = 1'b1;
            end
            OP_BEQ: begin
                decCalc    = 4'b0001;
                rtIsSource = 1'b1;
            end
            OP_ADDI: begin
                decWb   = 2'b10;
                decCalc = 4'b0100;
            end
            OP_ANDI, OP_ORI: begin
                decWb   = 2'b10;
                decCalc = 4'b0111;
                logicOp = 1'b1;
            end
            default: knownOp = 1'b0;
        endcase
    end

    // A used register field is out of range when it names a register beyond
    // REG_COUNT; the 6-bit compare keeps REG_COUNT=32 from wrapping to 0.
    logic rsOutOfRange;
    logic rtOutOfRange;
    logic rdOutOfRange;
    logic illegal;

    assign rsOutOfRange = {1'b0, rsField} >= 6'(REG_COUNT);
    assign rtOutOfRange = {1'b0, rtField} >= 6'(REG_COUNT);
    assign rdOutOfRange = {1'b0, rdField} >= 6'(REG_COUNT);
    assign illegal      = !knownOp || rsOutOfRange || rtOutOfRange || (usesRd && rdOutOfRange);

    // Load-use hazard against the load now sitting in ID/EX. The registered rt
    // is compared against the full 5-bit field so an out-of-range field never matches.
    logic [4:0] exRt;
    logic       loadUse;
    logic       stall;

    assign exRt    = 5'(rt);
    assign loadUse = idExValid && memAccessControl[1] && (rt != '0) && ifIdValid &&
                     ((exRt == rsField) || (rtIsSource && (exRt == rtField)));
    assign stall   = loadUse && !flush && !reset;

    assign pcWrite   = !stall;
    assign ifIdWrite = !stall;

    logic issue;
    logic flagIllegal;

    assign issue       = ifIdValid && !flush && !loadUse && !illegal;
    assign flagIllegal = ifIdValid && !flush && !loadUse && illegal;

    // Register file with same-cycle write-through
    logic [DATA_WIDTH-1:0] regFile [REG_COUNT];
    logic                  wbActive;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;

    assign wbActive = regWrite && (writeRegister != '0);

    always_comb begin
        operand1 = regFile[rsIdx];
        operand2 = regFile[rtIdx];
        if (rsIdx == '0)
            operand1 = '0;
        else if (wbActive && (writeRegister == rsIdx))
            operand1 = writeData;
        if (rtIdx == '0)
            operand2 = '0;
        else if (wbActive && (writeRegister == rtIdx))
            operand2 = writeData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                regFile[i] <= '0;
        end else if (wbActive) begin
            regFile[writeRegister] <= writeData;
        end
    end

    // Immediate extension
    logic [DATA_WIDTH-1:0] signExtImm;
    logic [DATA_WIDTH-1:0] zeroExtImm;
    logic [DATA_WIDTH-1:0] extImm;

    assign signExtImm = DATA_WIDTH'($signed(imm));
    assign zeroExtImm = DATA_WIDTH'(imm);
    assign extImm     = (LOGIC_ZERO_EXT && logicOp) ? zeroExtImm : signExtImm;

    // ID/EX latch: bubbles clear only the control/valid bits, data always loads
    always_ff @(posedge clk) begin
        if (reset) begin
            writeBackControl   <= '0;
            memAccessControl   <= '0;
            calculationControl <= '0;
            programCounterOut  <= '0;
            readData1          <= '0;
            readData2          <= '0;
            immediateOperand   <= '0;
            rs                 <= '0;
            rt                 <= '0;
            rd                 <= '0;
            idExValid          <= 1'b0;
            illegalInstruction <= 1'b0;
        end else begin
            writeBackControl   <= issue ? decWb   : 2'b00;
            memAccessControl   <= issue ? decMem  : 2'b00;
            calculationControl <= issue ? decCalc : 4'b0000;
            programCounterOut  <= programCounterIn;
            readData1          <= operand1;
            readData2          <= operand2;
            immediateOperand   <= extImm;
            rs                 <= rsIdx;
            rt                 <= rtIdx;
            rd                 <= rdIdx;
            idExValid          <= issue;
            illegalInstruction <= flagIllegal;
        end
    end

endmodule

// File: tb/tb_decode_stage_param.sv
// tb/tb_decode_stage_param.sv - self-checking bench for decode_stage_param
module tb_decode_stage_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Instance A: defaults (32-bit, 32 registers, zero-extended logic immediates)
    logic        rstA = 1'b1, vA = 1'b0, flA = 1'b0, weA = 1'b0;
    logic [31:0] pcA = '0, insA = '0, wdA = '0;
    logic [4:0]  wrA = '0;
    logic [1:0]  wbA, mA;
    logic [3:0]  exA;
    logic [31:0] pcoA, rd1A, rd2A, immA;
    logic [4:0]  rsA, rtA, rdA;
    logic        ivA, illA, pcwA, ifwA;

    // Instance B: 16-bit, 8 registers, sign-extend everything
    logic        rstB = 1'b1, vB = 1'b0, flB = 1'b0, weB = 1'b0;
    logic [15:0] pcB = '0, wdB = '0;
    logic [31:0] insB = '0;
    logic [2:0]  wrB = '0;
    logic [1:0]  wbB, mB;
    logic [3:0]  exB;
    logic [15:0] pcoB, rd1B, rd2B, immB;
    logic [2:0]  rsB, rtB, rdB;
    logic        ivB, illB, pcwB, ifwB;

    decode_stage_param dutA (
        .clk(clk), .reset(rstA), .programCounterIn(pcA), .instruction(insA),
        .ifIdValid(vA), .flush(flA), .writeRegister(wrA), .writeData(wdA), .regWrite(weA),
        .writeBackControl(wbA), .memAccessControl(mA), .calculationControl(exA),
        .programCounterOut(pcoA), .readData1(rd1A), .readData2(rd2A), .immediateOperand(immA),
        .rs(rsA), .rt(rtA), .rd(rdA), .idExValid(ivA), .illegalInstruction(illA),
        .pcWrite(pcwA), .ifIdWrite(ifwA)
    );

    decode_stage_param #(.DATA_WIDTH(16), .REG_COUNT(8), .LOGIC_ZERO_EXT(1'b0)) dutB (
        .clk(clk), .reset(rstB), .programCounterIn(pcB), .instruction(insB),
        .ifIdValid(vB), .flush(flB), .writeRegister(wrB), .writeData(wdB), .regWrite(weB),
        .writeBackControl(wbB), .memAccessControl(mB), .calculationControl(exB),
        .programCounterOut(pcoB), .readData1(rd1B), .readData2(rd2B), .immediateOperand(immB),
        .rs(rsB), .rt(rtB), .rd(rdB), .idExValid(ivB), .illegalInstruction(illB),
        .pcWrite(pcwB), .ifIdWrite(ifwB)
    );

    // Reference model state, one slot per instance
    logic [63:0] mregs [2][32];
    logic        pValid [2];
    logic        pMemRead [2];
    int          pRt [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rType(input int s, input int t, input int d);
        return {6'b000000, 5'(s), 5'(t), 5'(d), 11'h020};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
        return {op, 5'(s), 5'(t), im};
    endfunction

    function automatic logic [63:0] modelRead(input int s, input int field, input int rc,
                                              input logic we, input int wr, input logic [63:0] wd);
        int idx;
        idx = field % rc;
        if (idx == 0) return 64'd0;
        if (we && wr != 0 && wr == idx) return wd;
        return mregs[s][idx];
    endfunction

    // One clock of stimulus on instance s, with model prediction and checks.
    task automatic step(input int s, input logic rst, input logic [63:0] pc, input logic [31:0] ins,
                        input logic v, input logic fl, input logic we, input int wr,
                        input logic [63:0] wdIn, output logic stalled, output logic pcwSeen);
        int dw, rc, op, rsf, rtf, rdf;
        logic zx, known, usesRt, badReg, haz, bubble;
        logic [7:0]  ctl, expCtl;
        logic [63:0] mask, wd, expImm, expRd1, expRd2, expPc;
        logic        expValid, expIll;
        logic [1:0]  oWb, oM;
        logic [3:0]  oEx;
        logic [63:0] oPc, oRd1, oRd2, oImm, oRs, oRt, oRd;
        logic        oV, oIll, oPcw, oIfw;

        dw = (s == 0) ? 32 : 16;
        rc = (s == 0) ? 32 : 8;
        zx = (s == 0);
        mask = (64'd1 << dw) - 64'd1;
        wd = wdIn & mask;

        @(negedge clk);
        if (s == 0) begin
            rstA = rst; pcA = pc[31:0]; insA = ins; vA = v; flA = fl; weA = we; wrA = 5'(wr); wdA = wd[31:0];
        end else begin
            rstB = rst; pcB = pc[15:0]; insB = ins; vB = v; flB = fl; weB = we; wrB = 3'(wr); wdB = wd[15:0];
        end
        #1;

        op  = int'(ins[31:26]);
        rsf = int'(ins[25:21]);
        rtf = int'(ins[20:16]);
        rdf = int'(ins[15:11]);
        known = 1'b1;
        ctl = 8'h00;
        case (op)
            6'h00:         ctl = 8'b10_00_1010;
            6'h23:         ctl = 8'b11_10_0100;
            6'h2b:         ctl = 8'b00_01_0100;
            6'h04:         ctl = 8'b00_00_0001;
            6'h08:         ctl = 8'b10_00_0100;
            6'h0c, 6'h0d:  ctl = 8'b10_00_0111;
            default:       known = 1'b0;
        endcase
        usesRt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
        badReg = (rsf >= rc) || (rtf >= rc) || (op == 6'h00 && rdf >= rc);
        haz = !rst && pValid[s] && pMemRead[s] && pRt[s] != 0 && v &&
              (pRt[s] == rsf || (usesRt && pRt[s] == rtf));
        stalled = haz && !fl;

        oPcw = (s == 0) ? pcwA : pcwB;
        oIfw = (s == 0) ? ifwA : ifwB;
        pcwSeen = oPcw;
        chk("pcWrite", {63'd0, oPcw}, {63'd0, !stalled});
        chk("ifIdWrite", {63'd0, oIfw}, {63'd0, !stalled});

        if (zx && (op == 6'h0c || op == 6'h0d)) expImm = {48'd0, ins[15:0]};
        else                                    expImm = {{48{ins[15]}}, ins[15:0]} & mask;
        expRd1 = modelRead(s, rsf, rc, we, wr, wd);
        expRd2 = modelRead(s, rtf, rc, we, wr, wd);
        expPc  = pc & mask;
        bubble = fl || !v || haz || !known || badReg;
        expCtl = bubble ? 8'h00 : ctl;
        expValid = !bubble;
        expIll = !fl && v && !haz && (!known || badReg);
        if (rst) begin
            expCtl = 8'h00; expValid = 1'b0; expIll = 1'b0;
            expImm = '0; expRd1 = '0; expRd2 = '0; expPc = '0;
        end

        @(posedge clk);
        #1;
        if (s == 0) begin
            oWb = wbA; oM = mA; oEx = exA; oPc = 64'(pcoA); oRd1 = 64'(rd1A); oRd2 = 64'(rd2A);
            oImm = 64'(immA); oRs = 64'(rsA); oRt = 64'(rtA); oRd = 64'(rdA); oV = ivA; oIll = illA;
        end else begin
            oWb = wbB; oM = mB; oEx = exB; oPc = 64'(pcoB); oRd1 = 64'(rd1B); oRd2 = 64'(rd2B);
            oImm = 64'(immB); oRs = 64'(rsB); oRt = 64'(rtB); oRd = 64'(rdB); oV = ivB; oIll = illB;
        end
        chk("controls", {56'd0, oWb, oM, oEx}, {56'd0, expCtl});
        chk("idExValid", {63'd0, oV}, {63'd0, expValid});
        chk("illegal", {63'd0, oIll}, {63'd0, expIll});
        chk("pcOut", oPc, expPc);
        chk("readData1", oRd1, expRd1);
        chk("readData2", oRd2, expRd2);
        chk("immediate", oImm, expImm);
        chk("rs", oRs, rst ? 64'd0 : 64'(rsf % rc));
        chk("rt", oRt, rst ? 64'd0 : 64'(rtf % rc));
        chk("rd", oRd, rst ? 64'd0 : 64'(rdf % rc));

        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[s][i] = '0;
        end else if (we && (wr % rc) != 0) begin
            mregs[s][wr % rc] = wd;
        end
        pValid[s]   = expValid;
        pMemRead[s] = expCtl[5];
        pRt[s]      = rst ? 0 : rtf % rc;
    endtask

    initial begin
        logic st, pw;
        logic [31:0] cur, curPc;
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h3f};
        for (int s = 0; s < 2; s++) begin
            pValid[s] = 1'b0; pMemRead[s] = 1'b0; pRt[s] = 0;
            for (int i = 0; i < 32; i++) mregs[s][i] = '0;
        end

        // Instance A: directed steps
        step(0, 1'b1, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("reset_pcWrite", {63'd0, pw}, 64'd1);
        step(0, 1'b0, 64'h4, 32'h0, 1'b0, 1'b0, 1'b1, 0, 64'hFFFF_FFFF, st, pw);
        step(0, 1'b0, 64'h8, 32'h0, 1'b0, 1'b0, 1'b1, 1, 64'h0000_1234, st, pw);
        step(0, 1'b0, 64'hC, rType(0, 1, 2), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_r0_reads_zero", 64'(rd1A), 64'd0);
        chk("tp_r1_value", 64'(rd2A), 64'h1234);
        chk("tp_rtype_ctl", {56'd0, wbA, mA, exA}, {56'd0, 8'b10_00_1010});
        step(0, 1'b0, 64'h10, iType(6'h08, 5, 6, 16'h0001), 1'b1, 1'b0, 1'b1, 5, 64'hDEAD_BEEF, st, pw);
        chk("tp_write_through", 64'(rd1A), 64'hDEAD_BEEF);

        step(0, 1'b0, 64'h14, iType(6'h23, 1, 3, 16'h0000), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        step(0, 1'b0, 64'h18, rType(3, 1, 7), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_stall_pcWrite", {63'd0, pw}, 64'd0);
        chk("tp_bubble_after_lw", {63'd0, ivA}, 64'd0);
        step(0, 1'b0, 64'h18, rType(3, 1, 7), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_add_resumes_pcWrite", {63'd0, pw}, 64'd1);
        chk("tp_add_issues", {63'd0, ivA}, 64'd1);

        step(0, 1'b0, 64'h1C, iType(6'h0c, 1, 8, 16'h8001), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_andi_zero_ext", 64'(immA), 64'h0000_8001);
        step(0, 1'b0, 64'h20, iType(6'h08, 1, 8, 16'h8001), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_addi_sign_ext", 64'(immA), 64'hFFFF_8001);

        step(0, 1'b0, 64'h24, iType(6'h23, 1, 4, 16'h0000), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        step(0, 1'b0, 64'h28, rType(4, 1, 9), 1'b1, 1'b1, 1'b0, 0, 64'h0, st, pw);
        chk("tp_flush_pcWrite", {63'd0, pw}, 64'd1);
        chk("tp_flush_bubble", {63'd0, ivA}, 64'd0);
        step(0, 1'b0, 64'h2C, 32'hFC00_0000, 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_illegal_flag", {63'd0, illA}, 64'd1);
        chk("tp_illegal_bubble", {63'd0, ivA}, 64'd0);
        step(0, 1'b0, 64'h30, rType(1, 2, 3), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tp_illegal_one_cycle", {63'd0, illA}, 64'd0);

        // Instance A: randomized run; a stalled instruction is held like IF/ID would
        st = 1'b0;
        cur = '0;
        curPc = '0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                cur = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 31)), 11'($urandom)};
                curPc = $urandom;
            end
            step(0, $urandom_range(0, 99) == 0, 64'(curPc), cur, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 64'($urandom), st, pw);
        end

        // Instance B: narrow configuration
        step(1, 1'b1, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 64'h0, st, pw);
        step(1, 1'b0, 64'h2, 32'h0, 1'b0, 1'b0, 1'b1, 7, 64'hABCD, st, pw);
        step(1, 1'b0, 64'h4, rType(9, 0, 1), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tpB_rs_out_of_range", {63'd0, illB}, 64'd1);
        step(1, 1'b0, 64'h6, rType(7, 0, 1), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tpB_r7_readable", 64'(rd1B), 64'hABCD);
        step(1, 1'b0, 64'h8, iType(6'h0c, 7, 2, 16'h8001), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tpB_andi_imm", 64'(immB), 64'h8001);
        step(1, 1'b1, 64'hA, 32'h0, 1'b0, 1'b0, 1'b1, 7, 64'h1111, st, pw);
        step(1, 1'b0, 64'hC, rType(7, 0, 1), 1'b1, 1'b0, 1'b0, 0, 64'h0, st, pw);
        chk("tpB_reset_clears_r7", 64'(rd1B), 64'd0);

        st = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!st) begin
                cur = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 9)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 9)), 11'($urandom)};
                curPc = $urandom;
            end
            step(1, $urandom_range(0, 99) == 0, 64'(curPc), cur, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 64'($urandom), st, pw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/decode_stage_param.md
# decode_stage_param

Parametrised instruction-decode stage for the pipelined microprocessor: decodes the IF/ID instruction, reads a parametrised register file with same-cycle write-through, detects load-use hazards, and registers the ID/EX pipeline latch. It is the successor of the fixed 32×32 decode stage: data width, register count and zero-extend mode are generic, and it adds a valid bit, flush, stall bubbles and illegal-opcode flagging.

## Interface
- DATA_WIDTH, 32, register/PC/immediate width; legal range 16–64.
- REG_COUNT, 32, number of architectural registers; legal values 8, 16, 32. ADDR_W = log2(REG_COUNT).
- LOGIC_ZERO_EXT, 1, if 1 andi/ori zero-extend the immediate; if 0 every immediate is sign-extended.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears every register, including the register file.
- programCounterIn  in  DATA_WIDTH  PC+4 from IF/ID.
- instruction  in  32  IF/ID instruction; fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0].
- ifIdValid  in  1  IF/ID slot holds a real instruction.
- flush  in  1  branch taken in EX; discard the instruction currently in decode.
- writeRegister  in  ADDR_W  write-back destination.
- writeData  in  DATA_WIDTH  write-back data.
- regWrite  in  1  write-back enable.
- writeBackControl  out  2  {regWrite, memToReg}, registered.
- memAccessControl  out  2  {memRead, memWrite}, registered.
- calculationControl  out  4  {regDst, aluSrc, aluOp[1:0]}, registered.
- programCounterOut  out  DATA_WIDTH  registered copy of programCounterIn.
- readData1, readData2  out  DATA_WIDTH  registered rs/rt operands.
- immediateOperand  out  DATA_WIDTH  registered extended immediate.
- rs, rt, rd  out  ADDR_W  registered register fields (low ADDR_W bits).
- idExValid  out  1  registered; ID/EX holds a real instruction.
- illegalInstruction  out  1  registered one-cycle flag; the instruction was converted to a bubble.
- pcWrite, ifIdWrite  out  1  combinational; 0 means stall.

## Operation
- Decoding (WB/M/EX):
  - 000000 R-type: 10/00/1010.
  - 100011 lw: 11/10/0100.
  - 101011 sw: 00/01/0100.
  - 000100 beq: 00/00/0001.
  - 001000 addi: 10/00/0100.
  - 001100 andi, 001101 ori: 10/00/0111.
- Illegal instructions are converted to a bubble (all controls 0, idExValid 0, illegalInstruction 1). An instruction is illegal if it has any other opcode, or if any used register field has nonzero bits above ADDR_W.
- Register file: REG_COUNT×DATA_WIDTH. Written on the edge when regWrite is 1 and writeRegister ≠ 0. Register 0 always reads 0.
- Write-through: if regWrite is 1, writeRegister ≠ 0 and writeRegister equals the rs or rt field, the corresponding read returns writeData in the same cycle.
- Immediate: sign-extend imm to DATA_WIDTH. Zero-extend instead for andi/ori when LOGIC_ZERO_EXT=1.
- Load-use hazard:
  - Condition: idExValid=1, memAccessControl[1]=1, registered rt ≠ 0, and ifIdValid=1.
  - Match: registered rt equals the current rs field, or equals the current rt field for R-type, sw or beq.
  - Response: pcWrite=0, ifIdWrite=0, and the next ID/EX is a bubble.
- flush has priority over both the hazard and decoding: pcWrite=1, ifIdWrite=1, next ID/EX is a bubble, illegalInstruction=0.
- ifIdValid=0 produces a bubble with no illegal flag and no stall.
- A bubble clears idExValid, writeBackControl, memAccessControl and calculationControl. The data fields (PC, operands, immediate, rs/rt/rd) still load from the current inputs.

## Timing
- Decode to ID/EX output latency: 1 cycle.
- pcWrite and ifIdWrite are valid in the same cycle as instruction; no registered delay.
- A load-use stall lasts exactly one cycle. On the next cycle the bubble in ID/EX clears the hazard condition.
- Reset values: all registered outputs 0, every register file entry 0. pcWrite and ifIdWrite read 1 while reset is asserted.
- Reset asserted mid-stall or mid-write: reset wins. The write-back in that cycle is dropped.
- Simultaneous write-back and read of the same register: the new value is returned (write-through).

## Test plan
- Reset, then write 0xFFFF_FFFF to r0 and 0x0000_1234 to r1. Decode R-type rs=0, rt=1, rd=2. Required next edge: readData1=0, readData2=0x1234, controls 10/00/1010, idExValid=1.
- In the same cycle, regWrite r5=0xDEAD_BEEF and decode rs=5. Required: readData1=0xDEAD_BEEF after one edge.
- Decode lw rt=3, then add rs=3. Required: pcWrite=ifIdWrite=0 for one cycle, a bubble follows lw, and the add issues one cycle later.
- Decode andi imm=0x8001. Required: immediateOperand=0x0000_8001 with LOGIC_ZERO_EXT=1, and 0xFFFF_8001 for addi imm=0x8001.
- Apply flush together with a load-use hazard. Required: pcWrite=1, next idExValid=0. Then opcode 111111: illegalInstruction=1 for one cycle, idExValid=0.
- REG_COUNT=8, DATA_WIDTH=16: decode R-type rs=9. Required: illegalInstruction=1. Writes to r7 are readable; reset mid-run clears r7 to 0.
